// File: rtl/conv_frame_packer_pkg.sv
// conv_pkg: shared geometry and writer-state encoding for the conv
// feature-map packer.
package conv_pkg;

  localparam int unsigned ROWS      = 30;
  localparam int unsigned COLS      = 10;
  localparam int unsigned DW        = 8;
  localparam int unsigned FRAME_PIX = ROWS * COLS;
  localparam int unsigned IDX_W     = $clog2(FRAME_PIX);

  // FILL: writer accepting pixels; FULL: writable bank holds a finished frame
  typedef enum logic {
    FILL = 1'b0,
    FULL = 1'b1
  } state_t;

endpackage

// File: rtl/conv_frame_packer_bank.sv
// conv_pack_bank: flat pixel register bank with a single byte-write port
// and the whole bank exposed as one packed row-major bus.
module conv_pack_bank #(
  parameter int unsigned NPIX = 300,
  parameter int unsigned DW   = 8,
  parameter int unsigned IW   = 9
) (
  input  logic             clk,
  input  logic             rst_b,
  input  logic             we,
  input  logic [IW-1:0]    idx,
  input  logic [DW-1:0]    wdata,
  output logic [0:NPIX*DW-1] data
);

  // Byte write into pixel slot idx; contents only cleared by reset
  always_ff @(posedge clk) begin
    if (!rst_b) begin
      data <= '0;
    end else if (we) begin
      data[idx*DW +: DW] <= wdata;
    end
  end

endmodule

// File: rtl/conv_frame_packer.sv
// conv_frame_packer: writer side of the conv feature-map buffer. Packs a
// valid/ready pixel stream row-major into `mem` and holds each completed
// frame until frame_ack.
// Build option: CONV_PACK_PINGPONG_EN adds a second bank so the next frame
// can be filled while the consumer still works on the current one.
module conv_frame_packer
  import conv_pkg::*;
#(
  parameter int unsigned ROWS = conv_pkg::ROWS,
  parameter int unsigned COLS = conv_pkg::COLS,
  parameter int unsigned DW   = conv_pkg::DW
) (
  input  logic                     clk,
  input  logic                     rst_b,
  input  logic                     s_valid,
  output logic                     s_ready,
  input  logic [DW-1:0]            s_data,
  input  logic                     s_last,
  output logic [0:ROWS*COLS*DW-1]  mem,
  output logic                     frame_valid,
  input  logic                     frame_ack,
  output logic                     err_len,
  output logic [7:0]               frame_cnt
);

  localparam int unsigned NPIX = ROWS * COLS;
  localparam int unsigned IW   = $clog2(NPIX);

  state_t          state_q;
  logic [IW-1:0]   wr_idx;
  logic            xfer;
  logic            at_last;
  logic            done;
  logic            ack;

  assign s_ready = (state_q == FILL);
  assign xfer    = s_valid && s_ready;
  assign at_last = (wr_idx == IW'(NPIX - 1));
  assign done    = xfer && at_last;
  assign ack     = frame_ack && frame_valid;

`ifdef CONV_PACK_PINGPONG_EN
  logic                 front_sel;
  logic [0:NPIX*DW-1]   data0;
  logic [0:NPIX*DW-1]   data1;

  // The bank not selected as front is the one being filled
  conv_pack_bank #(.NPIX(NPIX), .DW(DW), .IW(IW)) u_bank0 (
    .clk   (clk),
    .rst_b (rst_b),
    .we    (xfer && front_sel),
    .idx   (wr_idx),
    .wdata (s_data),
    .data  (data0)
  );

  conv_pack_bank #(.NPIX(NPIX), .DW(DW), .IW(IW)) u_bank1 (
    .clk   (clk),
    .rst_b (rst_b),
    .we    (xfer && !front_sel),
    .idx   (wr_idx),
    .wdata (s_data),
    .data  (data1)
  );

  assign mem = front_sel ? data1 : data0;
`else
  conv_pack_bank #(.NPIX(NPIX), .DW(DW), .IW(IW)) u_bank (
    .clk   (clk),
    .rst_b (rst_b),
    .we    (xfer),
    .idx   (wr_idx),
    .wdata (s_data),
    .data  (mem)
  );
`endif

  // Write pointer, length checking, frame counting and frame handoff
  always_ff @(posedge clk) begin
    if (!rst_b) begin
      state_q     <= FILL;
      wr_idx      <= '0;
      frame_valid <= 1'b0;
      err_len     <= 1'b0;
      frame_cnt   <= '0;
`ifdef CONV_PACK_PINGPONG_EN
      front_sel   <= 1'b0;
`endif
    end else begin
      err_len <= 1'b0;

      if (xfer) begin
        if (at_last) begin
          wr_idx    <= '0;
          frame_cnt <= frame_cnt + 1'b1;
          err_len   <= !s_last;
        end else if (s_last) begin
          wr_idx  <= '0;
          err_len <= 1'b1;
        end else begin
          wr_idx <= wr_idx + 1'b1;
        end
      end

`ifdef CONV_PACK_PINGPONG_EN
      // state_q tracks the back bank: FULL means it waits for the front to be released
      if (done) begin
        if (!frame_valid || ack) begin
          front_sel   <= ~front_sel;
          frame_valid <= 1'b1;
        end else begin
          state_q <= FULL;
        end
      end else if (ack) begin
        if (state_q == FULL) begin
          front_sel <= ~front_sel;
          state_q   <= FILL;
        end else begin
          frame_valid <= 1'b0;
        end
      end
`else
      if (done) begin
        state_q     <= FULL;
        frame_valid <= 1'b1;
      end else if (state_q == FULL && frame_ack) begin
        state_q     <= FILL;
        frame_valid <= 1'b0;
      end
`endif
    end
  end

endmodule

// File: tb/tb_conv_frame_packer.sv
// tb_conv_frame_packer: directed test of the single-bank packer build.
module tb_conv_frame_packer;

  localparam int unsigned ROWS = 30;
  localparam int unsigned COLS = 10;
  localparam int unsigned DW   = 8;
  localparam int unsigned NPIX = ROWS * COLS;

  logic                    clk = 1'b0;
  logic                    rst_b = 1'b0;
  logic                    s_valid = 1'b0;
  logic                    s_ready;
  logic [DW-1:0]           s_data = '0;
  logic                    s_last = 1'b0;
  logic [0:NPIX*DW-1]      mem;
  logic                    frame_valid;
  logic                    frame_ack = 1'b0;
  logic                    err_len;
  logic [7:0]              frame_cnt;

  int unsigned checks = 0;
  int unsigned errors = 0;
  int unsigned err_pulses = 0;

  conv_frame_packer #(.ROWS(ROWS), .COLS(COLS), .DW(DW)) dut (
    .clk         (clk),
    .rst_b       (rst_b),
    .s_valid     (s_valid),
    .s_ready     (s_ready),
    .s_data      (s_data),
    .s_last      (s_last),
    .mem         (mem),
    .frame_valid (frame_valid),
    .frame_ack   (frame_ack),
    .err_len     (err_len),
    .frame_cnt   (frame_cnt)
  );

  always #5 clk = ~clk;

  always @(negedge clk) if (err_len) err_pulses++;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=0x%0h expected=0x%0h", tag, got, exp);
    end
  endtask

  function automatic logic [7:0] pix(input int unsigned k);
    return mem[k*DW +: DW];
  endfunction

  // One pixel transfer, optionally preceded by idle cycles; returns #1 after the accepting edge
  task automatic push(input logic [7:0] d, input logic last, input int unsigned gap);
    int unsigned n;
    repeat (gap) @(negedge clk);
    @(negedge clk);
    s_valid = 1'b1;
    s_data  = d;
    s_last  = last;
    n = 0;
    while (!s_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (n == 50) check("ready_timeout", 32'd0, 32'd1);
    @(posedge clk);
    #1;
    s_valid = 1'b0;
    s_last  = 1'b0;
  endtask

  task automatic ack_frame();
    @(negedge clk);
    frame_ack = 1'b1;
    @(posedge clk);
    #1;
    frame_ack = 1'b0;
  endtask

  initial begin
    int unsigned bad;
    int unsigned pulses0;

    // Reset state
    repeat (2) @(posedge clk);
    #1;
    check("rst_frame_valid", 32'(frame_valid), 32'd0);
    check("rst_s_ready",     32'(s_ready),     32'd1);
    check("rst_frame_cnt",   32'(frame_cnt),   32'd0);
    check("rst_err_len",     32'(err_len),     32'd0);
    check("rst_mem0",        32'(pix(0)),      32'd0);
    rst_b = 1'b1;

    // Frame 1: value k mod 256, continuous
    for (int unsigned k = 0; k < NPIX - 1; k++) push(8'(k), 1'b0, 0);
    check("f1_not_yet_valid", 32'(frame_valid), 32'd0);
    push(8'(NPIX - 1), 1'b1, 0);
    check("f1_frame_valid", 32'(frame_valid), 32'd1);
    check("f1_s_ready",     32'(s_ready),     32'd0);
    check("f1_frame_cnt",   32'(frame_cnt),   32'd1);
    check("f1_mem0",        32'(pix(0)),      32'h00);
    check("f1_mem100",      32'(pix(100)),    32'h64);
    check("f1_mem299",      32'(pix(299)),    32'h2B);
    check("f1_no_err",      32'(err_pulses),  32'd0);

    // Frame held while full: offered pixels are not taken
    @(negedge clk);
    s_valid = 1'b1;
    s_data  = 8'hFF;
    repeat (3) @(posedge clk);
    #1;
    s_valid = 1'b0;
    check("full_mem0_frozen", 32'(pix(0)),    32'h00);
    check("full_still_valid", 32'(frame_valid), 32'd1);

    ack_frame();
    check("ack_frame_valid", 32'(frame_valid), 32'd0);
    check("ack_s_ready",     32'(s_ready),     32'd1);
    ack_frame();
    check("idle_ack_ignored", 32'(frame_cnt),  32'd1);

    // Frame 2: all 0xA5 with random gaps
    pulses0 = err_pulses;
    for (int unsigned k = 0; k < NPIX; k++) push(8'hA5, k == NPIX - 1, $urandom_range(0, 2));
    bad = 0;
    for (int unsigned k = 0; k < NPIX; k++) if (pix(k) != 8'hA5) bad++;
    check("f2_bad_bytes",  32'(bad),        32'd0);
    check("f2_frame_cnt",  32'(frame_cnt),  32'd2);
    check("f2_no_err",     32'(err_pulses - pulses0), 32'd0);
    ack_frame();

    // Short frame: s_last on pixel 150
    for (int unsigned k = 0; k < 151; k++) push(8'h11, k == 150, 0);
    check("short_err_len",     32'(err_len),     32'd1);
    check("short_frame_valid", 32'(frame_valid), 32'd0);
    check("short_frame_cnt",   32'(frame_cnt),   32'd2);
    @(posedge clk);
    #1;
    check("short_err_one_cycle", 32'(err_len), 32'd0);
    for (int unsigned k = 0; k < NPIX; k++) push(8'(k * 3), k == NPIX - 1, 0);
    check("f3_frame_valid", 32'(frame_valid), 32'd1);
    check("f3_frame_cnt",   32'(frame_cnt),   32'd3);
    check("f3_mem0",        32'(pix(0)),      32'h00);
    check("f3_mem150",      32'(pix(150)),    32'hC2);
    check("f3_mem299",      32'(pix(299)),    32'h81);
    ack_frame();

    // Full length but no s_last: completes and flags
    for (int unsigned k = 0; k < NPIX; k++) push(8'h5A, 1'b0, 0);
    check("nolast_err_len",     32'(err_len),     32'd1);
    check("nolast_frame_valid", 32'(frame_valid), 32'd1);
    check("nolast_frame_cnt",   32'(frame_cnt),   32'd4);
    ack_frame();

    // Reset mid-frame, then a full frame
    for (int unsigned k = 0; k < 200; k++) push(8'h33, 1'b0, 0);
    @(negedge clk);
    rst_b = 1'b0;
    @(posedge clk);
    #1;
    rst_b = 1'b1;
    check("midrst_frame_cnt", 32'(frame_cnt), 32'd0);
    check("midrst_mem0",      32'(pix(0)),    32'h00);
    for (int unsigned k = 0; k < NPIX - 1; k++) push(8'h77, 1'b0, 0);
    check("midrst_299_not_valid", 32'(frame_valid), 32'd0);
    push(8'h77, 1'b1, 0);
    check("midrst_frame_valid", 32'(frame_valid), 32'd1);
    check("midrst_frame_cnt1",  32'(frame_cnt),   32'd1);
    check("midrst_mem250",      32'(pix(250)),    32'h77);
    check("midrst_mem299",      32'(pix(299)),    32'h77);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout got=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/conv_frame_packer.md
Name: conv_frame_packer

Overview:
- Writer side of the conv feature-map buffer.
- Accepts an 8-bit pixel stream with a valid/ready handshake and packs it row-major into the flat ROWS*COLS*DW-bit `mem` bus read by the conv data selector.
- Flags each completed frame and holds it stable until the consumer acknowledges it.
- Sits between the upstream pixel source (previous layer / input loader) and the Conv_11_7_1 window selector.

Parameters:
- ROWS, 30, feature-map rows.
- COLS, 10, feature-map columns.
- DW, 8, bits per pixel.

Ports:
- clk  input  1  clock, all logic on posedge.
- rst_b  input  1  synchronous active-low reset, sampled on posedge clk.
- s_valid  input  1  upstream pixel valid.
- s_ready  output  1  packer can accept a pixel this cycle.
- s_data  input  DW  pixel value.
- s_last  input  1  marks the final pixel of a frame.
- mem  output  [0:ROWS*COLS*DW-1]  packed frame; pixel k = row*COLS+col occupies mem[k*DW +: DW].
- frame_valid  output  1  mem holds a complete frame.
- frame_ack  input  1  consumer has finished with the current frame.
- err_len  output  1  one-cycle pulse on a frame-length mismatch.
- frame_cnt  output  8  count of completed frames, wraps 255→0.

Behaviour:
- Reset (rst_b=0 at posedge):
  - state=FILL, wr_idx=0, mem=0, frame_valid=0, err_len=0, frame_cnt=0.
  - Reset mid-frame discards the partial frame.
- Transfer occurs when s_valid && s_ready. s_ready is combinational from state only; no dependence on s_valid.
- State FILL:
  - s_ready=1.
  - Each transfer writes s_data to byte wr_idx; wr_idx increments by 1.
  - Transfer at wr_idx=FRAME_PIX-1 (299) → next cycle state=FULL, frame_valid=1, frame_cnt+1, wr_idx=0.
- State FULL:
  - s_ready=0; mem frozen.
  - frame_ack=1 → next cycle state=FILL, frame_valid=0.
  - frame_ack while frame_valid=0 is ignored.
- Latency: last pixel accepted in cycle N → frame_valid high in cycle N+1, mem final in cycle N+1.
- Length checks:
  - s_last at wr_idx<299: pixel is written, err_len pulses next cycle, wr_idx returns to 0, frame discarded (no frame_valid, frame_cnt unchanged).
  - Transfer at wr_idx=299 with s_last=0: frame still completes, err_len pulses.
- mem is never cleared except by reset; bytes not yet overwritten keep stale values during FILL.
- wr_idx width: clog2(FRAME_PIX); no wrap beyond 299.

Optional Feature:
- Macro: CONV_PACK_PINGPONG_EN.
- Defined: two banks, front (drives mem) and back (filled).
  - s_ready=1 unless both banks hold complete frames.
  - Back bank completes while frame_valid=0 → swap next cycle, frame_valid=1.
  - Back bank completes while frame_valid=1 → back is marked full, s_ready=0 until ack.
  - frame_ack with a full back bank → swap next cycle, frame_valid stays 1, s_ready reasserts.
  - frame_ack and the final back pixel in the same cycle → both take effect; next cycle front = new frame, frame_valid=1.
- Undefined: single bank exactly as above; s_ready=0 whenever frame_valid=1.

Decomposition:
- Package conv_pkg:
  - ROWS, COLS, DW, FRAME_PIX=ROWS*COLS, IDX_W.
  - State enum {FILL, FULL}.
- One sub-module: conv_pack_bank, a flat register bank with byte-write port (we, idx, wdata) and the full packed output. Instantiated once, or twice under the macro.

Test Plan:
- 300 pixels, value = k mod 256, s_valid constant, no ack → frame_valid at cycle 301; mem[0:7]=0x00, mem[299*8+:8]=0x2B; s_ready=0; frame_cnt=1.
- Ack after frame 1, then a second frame of value 0xA5 with random s_valid gaps → all bytes 0xA5, frame_cnt=2, no err_len.
- s_last on pixel 150 → err_len pulse, frame_valid stays 0; next 300 pixels form a valid frame.
- Reset asserted at pixel 200, then 300 pixels → frame_valid after exactly 300 transfers, frame_cnt=1.
- PINGPONG: stream 600 pixels, no ack → s_ready drops after pixel 599; ack → mem switches to frame 2 next cycle, frame_valid stays 1.
- PINGPONG: ack coincident with pixel 599 → frame_valid stays 1, mem = frame 2, s_ready=1 the next cycle.
